// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART word receiver.
//   bit_state_e  : bit-level deserializer states
//   word_state_e : byte-pair assembler states
//   OVERSAMPLE_DEFAULT, MID_SAMPLE, DATA_BITS : frame timing constants
//   mid_sample() : mid-bit tick index for an arbitrary oversample ratio
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEFAULT = 16;
   localparam int unsigned MID_SAMPLE         = OVERSAMPLE_DEFAULT / 2 - 1;
   localparam int unsigned DATA_BITS          = 8;

   typedef enum logic [2:0] {
      BitIdle,
      BitStart,
      BitData,
      BitParity,
      BitStop
   } bit_state_e;

   typedef enum logic {
      WHigh,
      WLow
   } word_state_e;

   function automatic int unsigned mid_sample(input int unsigned os);
      return os / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchronizer plus 8N1 bit-level deserializer.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   baud_tick   : one-clk pulse at OVERSAMPLE x baud rate
//   rx          : asynchronous serial line, idle high
//   byte_data   : last shifted byte (valid while byte_valid is high)
//   byte_valid  : combinational pulse on the stop-sample tick of a good frame
//   frame_err   : combinational pulse on the stop-sample tick when stop bit is 0
//   parity_err  : combinational pulse on the parity-sample tick on mismatch
//   start_det   : combinational pulse on the tick that enters START
//   idle        : bit FSM is in IDLE
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] byte_data,
   output logic                 byte_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 start_det,
   output logic                 idle
);

   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW = $clog2(DATA_BITS);
   localparam logic [CntW-1:0] MidCnt  = CntW'(mid_sample(OVERSAMPLE));
   localparam logic [CntW-1:0] LastCnt = CntW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   bit_state_e             state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
   logic                   par_bad_q, par_bad_d;
`endif

   // Synchronizer resets to 1 so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BitIdle;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      parity_err = 1'b0;
      start_det  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d  = par_bad_q;
`endif
      if (baud_tick) begin
         unique case (state_q)
            BitIdle: begin
               if (!rx_s) begin
                  state_d   = BitStart;
                  cnt_d     = '0;
                  start_det = 1'b1;
               end
            end
            BitStart: begin
               if (cnt_q == MidCnt) begin
                  // Line back high at mid start bit: treat as a glitch.
                  state_d   = rx_s ? BitIdle : BitData;
                  cnt_d     = '0;
                  bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            BitData: begin
               if (cnt_q == LastCnt) begin
                  cnt_d   = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};  // LSB first
                  if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                     state_d = BitParity;
`else
                     state_d = BitStop;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            BitParity: begin
               if (cnt_q == LastCnt) begin
                  cnt_d      = '0;
                  parity_err = ^{shift_q, rx_s};  // even parity over data + parity bit
                  par_bad_d  = parity_err;
                  state_d    = BitStop;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
            BitStop: begin
               if (cnt_q == LastCnt) begin
                  // Return to IDLE at the stop sample so the next start edge is not missed.
                  state_d = BitIdle;
                  cnt_d   = '0;
                  if (!rx_s) begin
                     frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (!par_bad_q) begin
`else
                  end else begin
`endif
                     byte_valid = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = BitIdle;
         endcase
      end
   end

   assign byte_data = shift_q;
   assign idle      = (state_q == BitIdle);

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: UART receiver that pairs bytes (high first) into 16-bit words.
// Build option: define UART_RX_PARITY_EN for an even-parity bit per frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   baud_tick   : one-clk pulse at OVERSAMPLE x baud rate
//   rx          : asynchronous serial line, idle high
//   word_data   : last assembled word {high_byte, low_byte}, held until the next
//   word_valid  : one-clk pulse when word_data updates
//   frame_err   : one-clk pulse on a bad stop bit
//   parity_err  : one-clk pulse on parity mismatch (0 without UART_RX_PARITY_EN)
//   busy        : high from start detect until the word completes or is discarded
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int unsigned GAP_TICKS   = 512,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        baud_tick,
   input  logic        rx,
   output logic [15:0] word_data,
   output logic        word_valid,
   output logic        frame_err,
   output logic        parity_err,
   output logic        busy
);

   localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_TICKS - 1);

   logic [DATA_BITS-1:0] byte_data;
   logic                 byte_valid;
   logic                 byte_frame_err;
   logic                 byte_parity_err;
   logic                 start_det;
   logic                 byte_idle;

   word_state_e          wstate_q, wstate_d;
   logic [7:0]           high_q, high_d;
   logic [15:0]          word_q, word_d;
   logic                 word_valid_q, word_valid_d;
   logic                 frame_err_q;
   logic [GapW-1:0]      gap_q, gap_d;
   logic                 busy_q, busy_d;

   uart_rx_byte #(
      .OVERSAMPLE  (OVERSAMPLE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_byte (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (byte_frame_err),
      .parity_err (byte_parity_err),
      .start_det  (start_det),
      .idle       (byte_idle)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q     <= WHigh;
         high_q       <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         gap_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         wstate_q     <= wstate_d;
         high_q       <= high_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= byte_frame_err;
         gap_q        <= gap_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      wstate_d     = wstate_q;
      high_d       = high_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      gap_d        = gap_q;
      busy_d       = busy_q;

      if (byte_valid) begin
         if (wstate_q == WHigh) begin
            high_d   = byte_data;
            wstate_d = WLow;
            gap_d    = '0;
         end else begin
            word_d       = {high_q, byte_data};
            word_valid_d = 1'b1;
            wstate_d     = WHigh;
         end
      end else if (byte_frame_err || byte_parity_err) begin
         wstate_d = WHigh;
      end else if (wstate_q == WLow && baud_tick && byte_idle && !start_det) begin
         // Gap only runs while the bit FSM is idle; a start on the last tick wins.
         if (gap_q == GapLast) begin
            wstate_d = WHigh;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end

      if (start_det) begin
         busy_d = 1'b1;
      end else if (wstate_q == WHigh && byte_idle) begin
         busy_d = 1'b0;
      end
   end

   assign word_data  = word_q;
   assign word_valid = word_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= byte_parity_err;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed, table-driven bench for uart_rx_word.
module tb_uart_rx_word;

   localparam int unsigned OS  = 16;
   localparam int unsigned GAP = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        baud_tick;
   logic        rx;
   logic [15:0] word_data;
   logic        word_valid;
   logic        frame_err;
   logic        parity_err;
   logic        busy;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   int unsigned wv_cnt = 0;
   int unsigned fe_cnt = 0;
   int unsigned pe_cnt = 0;
   int unsigned w0, f0, p0;

   typedef struct {
      int unsigned n;          // frames in this row
      logic [23:0] d;          // frame bytes, first frame in the top byte
      logic [2:0]  stop_ok;    // stop bit value per frame, first frame in bit 2
      int unsigned exp_words;
      logic [15:0] exp_word;
      int unsigned exp_ferr;
   } vec_t;

   vec_t vecs [7];

   uart_rx_word #(
      .OVERSAMPLE  (OS),
      .GAP_TICKS   (GAP),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .rx         (rx),
      .word_data  (word_data),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_valid === 1'b1) wv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
   endtask

   task automatic ticks(input int unsigned n);
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      ticks(OS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int b = 0; b < 8; b++) send_bit(d[b]);
`ifdef UART_RX_PARITY_EN
      send_bit(^d);
`endif
      send_bit(stop);
      rx = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_badpar(input logic [7:0] d);
      send_bit(1'b0);
      for (int b = 0; b < 8; b++) send_bit(d[b]);
      send_bit(~^d);
      send_bit(1'b1);
      rx = 1'b1;
   endtask
`endif

   initial begin
      logic [7:0] lo;
      vecs[0] = '{2, 24'h123400, 3'b110, 1, 16'h1234, 0};
      vecs[1] = '{3, 24'h77ABCD, 3'b011, 1, 16'hABCD, 1};
      vecs[2] = '{2, 24'h5AA500, 3'b110, 1, 16'h5AA5, 0};
      vecs[3] = '{2, 24'h00FF00, 3'b110, 1, 16'h00FF, 0};
      vecs[4] = '{2, 24'h112200, 3'b100, 0, 16'h00FF, 1};  // low byte bad stop
      vecs[5] = '{2, 24'hFF0000, 3'b110, 1, 16'hFF00, 0};
      vecs[6] = '{2, 24'h800100, 3'b110, 1, 16'h8001, 0};

      rst       = 1'b1;
      baud_tick = 1'b0;
      rx        = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_word_data", 32'(word_data), 32'h0);
      check("reset_word_valid", 32'(word_valid), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_parity_err", 32'(parity_err), 32'h0);

      for (int r = 0; r < 7; r++) begin
         w0 = wv_cnt;
         f0 = fe_cnt;
         for (int i = 0; i < int'(vecs[r].n); i++) begin
            send_frame(vecs[r].d[23-8*i -: 8], vecs[r].stop_ok[2-i]);
            ticks(OS);
         end
         check($sformatf("row%0d_words", r), wv_cnt - w0, vecs[r].exp_words);
         check($sformatf("row%0d_data", r), 32'(word_data), 32'(vecs[r].exp_word));
         check($sformatf("row%0d_ferr", r), fe_cnt - f0, vecs[r].exp_ferr);
         check($sformatf("row%0d_busy", r), 32'(busy), 32'h0);
      end

      // Latency: word_valid must appear right after the low-byte stop-sample tick.
      send_frame(8'hBE, 1'b1);
      ticks(OS);
      lo = 8'hEF;
      send_bit(1'b0);
      for (int b = 0; b < 8; b++) send_bit(lo[b]);
`ifdef UART_RX_PARITY_EN
      send_bit(^lo);
`endif
      rx = 1'b1;
      ticks(OS / 2);
      check("lat_early", 32'(word_valid), 32'h0);
      tick();
      check("lat_valid", 32'(word_valid), 32'h1);
      check("lat_data", 32'(word_data), 32'hBEEF);
      @(negedge clk);
      check("lat_pulse_width", 32'(word_valid), 32'h0);
      ticks(OS + OS / 2);

      // Start-bit glitch: no byte, no error, busy drops again.
      w0 = wv_cnt;
      f0 = fe_cnt;
      rx = 1'b0;
      ticks(2);
      check("glitch_busy_set", 32'(busy), 32'h1);
      ticks(2);
      rx = 1'b1;
      ticks(20);
      check("glitch_words", wv_cnt - w0, 32'h0);
      check("glitch_ferr", fe_cnt - f0, 32'h0);
      check("glitch_busy_clear", 32'(busy), 32'h0);
      check("glitch_data", 32'(word_data), 32'hBEEF);

      // Gap boundary: start lands on the GAP-th idle tick after the stop sample.
      w0 = wv_cnt;
      send_frame(8'h55, 1'b1);
      ticks(GAP - 8);
      send_frame(8'h66, 1'b1);
      ticks(OS);
      check("gap_edge_words", wv_cnt - w0, 32'h1);
      check("gap_edge_data", 32'(word_data), 32'h5566);

      // Gap timeout: one tick later the high byte is discarded.
      w0 = wv_cnt;
      send_frame(8'h55, 1'b1);
      ticks(GAP - 7);
      @(negedge clk);
      check("gap_timeout_busy", 32'(busy), 32'h0);
      send_frame(8'h01, 1'b1);
      ticks(OS);
      send_frame(8'h02, 1'b1);
      ticks(OS);
      check("gap_timeout_words", wv_cnt - w0, 32'h1);
      check("gap_timeout_data", 32'(word_data), 32'h0102);

      // Reset in the middle of the low byte 0x9A.
      send_frame(8'h11, 1'b1);
      ticks(OS);
      w0 = wv_cnt;
      f0 = fe_cnt;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      rx = 1'b0;
      ticks(5);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ticks(20);
      check("rst_words", wv_cnt - w0, 32'h0);
      check("rst_ferr", fe_cnt - f0, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_data", 32'(word_data), 32'h0);
      w0 = wv_cnt;
      send_frame(8'h10, 1'b1);
      ticks(OS);
      send_frame(8'h20, 1'b1);
      ticks(OS);
      check("post_rst_words", wv_cnt - w0, 32'h1);
      check("post_rst_data", 32'(word_data), 32'h1020);

`ifdef UART_RX_PARITY_EN
      w0 = wv_cnt;
      p0 = pe_cnt;
      send_frame_badpar(8'h03);
      ticks(OS);
      check("par_err_pulse", pe_cnt - p0, 32'h1);
      check("par_err_words", wv_cnt - w0, 32'h0);
      send_frame(8'h03, 1'b1);
      ticks(OS);
      send_frame(8'h04, 1'b1);
      ticks(OS);
      check("par_ok_words", wv_cnt - w0, 32'h1);
      check("par_ok_data", 32'(word_data), 32'h0304);
`else
      p0 = 0;
      check("parity_quiet", pe_cnt - p0, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
